// File: rtl/pipeline_sum_accumulator.sv
// pipeline_sum_accumulator: accumulates {cout,sum} beats into block totals and hands each block
// out as one registered record over valid/ready, stalling input while the record is pending.
module pipeline_sum_accumulator #(
  parameter int ACC_W     = 16,
  parameter int MAX_COUNT = 255,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam int SW = ACC_W + 1;
  typedef enum logic {ACC, DONE} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SW-1:0]    sum_n;
  logic             ovf, ovf_n, take, term;
  assign sum_n = {1'b0, acc} + SW'({in_cout, in_sum});
  assign cnt_n = cnt + CNT_W'(1);
  assign ovf_n = ovf | sum_n[ACC_W];
  assign take  = in_valid && in_ready;
  // in_last and the count limit on the same beat collapse into one termination
  assign term  = in_last || cnt_n == CNT_W'(MAX_COUNT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ACC;
    else state <= state_n;
  always_comb
    state_n = state == ACC ? (take && term ? DONE : ACC) : (out_ready ? ACC : DONE);
  always_comb
    in_ready = state == ACC && !clr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (take && term) begin
        out_data  <= sum_n[ACC_W-1:0];
        out_count <= cnt_n;
        out_ovf   <= ovf_n;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else if (take) begin
        acc <= sum_n[ACC_W-1:0];
        cnt <= cnt_n;
        ovf <= ovf_n;
      end else if (clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/pipeline_sum_accumulator.md
Name: pipeline_sum_accumulator

Overview:
Downstream consumer stage for the pipelined 8-bit adder. It takes each 9-bit result {cout,sum} and accumulates the results into a wide running total. A block of results ends on an explicit last flag or when a beat-count limit is reached. At that point the block emits one registered result record (total, beat count, overflow flag) over a valid/ready handshake, stalling the input while the record is pending.

Parameters:
ACC_W, 16, accumulator and out_data width in bits; must be >= 9
MAX_COUNT, 255, maximum beats per block before forced termination; must be >= 1
CNT_W, 8, count width in bits; must satisfy 2^CNT_W > MAX_COUNT

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous flush of the partial block; the pending output record is unaffected
in_valid  input  1  in_sum/in_cout/in_last are valid
in_ready  output  1  beat accepted on a rising clk edge when in_valid && in_ready
in_sum  input  8  adder sum
in_cout  input  1  adder carry-out
in_last  input  1  final beat of the current block
out_valid  output  1  result record valid
out_ready  input  1  consumer accepts the record
out_data  output  ACC_W  block total, modulo 2^ACC_W
out_count  output  CNT_W  number of beats in the block
out_ovf  output  1  1 if any addition in the block carried out of ACC_W

Behaviour:
- Reset (rst=0, asynchronous): state=ACC; acc=0, cnt=0, ovf_sticky=0; out_valid=0, out_data=0, out_count=0, out_ovf=0. Reset mid-block or mid-handshake discards everything.
- State ACC: in_ready = !clr (combinational). State DONE: in_ready = 0.
- Beat value v = zero-extended {in_cout,in_sum}, range 0..511.
- Accept in ACC:
  - sum_n = acc + v computed at ACC_W+1 bits; c = bit ACC_W of sum_n.
  - cnt_n = cnt + 1.
  - ovf_n = ovf_sticky | c.
- Accepted beat with in_last=1 or cnt_n==MAX_COUNT (terminating beat):
  - out_data <= sum_n[ACC_W-1:0]; out_count <= cnt_n; out_ovf <= ovf_n; out_valid <= 1.
  - acc, cnt, ovf_sticky <= 0; state <= DONE.
  - out_valid rises on the edge that accepts the terminating beat, so it is visible the next cycle. Latency is one cycle.
- Accepted beat that does not terminate: acc <= sum_n[ACC_W-1:0]; cnt <= cnt_n; ovf_sticky <= ovf_n.
- State DONE:
  - out_data, out_count and out_ovf are held stable while out_valid=1.
  - On an edge with out_ready=1: out_valid <= 0 and state <= ACC.
  - out_data, out_count and out_ovf keep their last values after the handshake.
  - No beat can be accepted on the handshake edge. The first new beat can be accepted on the following edge.
- clr (synchronous):
  - In ACC: acc, cnt, ovf_sticky <= 0. Since in_ready=0, no beat is consumed that cycle (clr has priority over in_valid).
  - In DONE: the pending record and handshake proceed unchanged; acc is already 0.
- in_last with cnt_n==MAX_COUNT produces a single termination, not two.
- in_valid while in_ready=0 is a stall, not a loss. The producer holds the beat.
- out_ready is ignored while out_valid=0.
- All outputs are registered except in_ready.

Test Plan:
- Reset: assert rst=0 asynchronously mid-cycle -> immediately out_valid=0, out_data=0, out_count=0, out_ovf=0; after release with clr=0, in_ready=1.
- Basic block: beats {cout,sum}={0,0x10},{1,0xFF},{0,0x01}, last on the third, out_ready=1 -> one cycle after the third accept: out_valid=1, out_data=0x0210, out_count=3, out_ovf=0; out_valid=0 the next cycle.
- Count limit: 255 beats of {0,0x01}, in_last=0 -> out_valid after the 255th accept with out_data=0x00FF, out_count=255, out_ovf=0; the next block starts from acc=0.
- Overflow: 200 beats of {1,0xFF}, last on the 200th -> out_data=0x8F38, out_count=200, out_ovf=1; the following 1-beat block {0,0x05} with last -> out_data=0x0005, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_* stable throughout, no beat consumed. Then raise out_ready -> out_valid=0 next cycle, and the held beat is accepted on the edge after that.
- Flush/reset mid-block: accept 2 beats of {0,0x20}, then pulse clr with in_valid=1, then 1 beat {0,0x03} with last -> out_data=0x0003, out_count=1. Repeat with rst pulsed instead of clr -> same result.
